// File: rtl/serial_demux_ctrl_if.sv
// rtl/serial_demux_ctrl_if.sv - control/status bundle between serial demux controller and its datapath
//
// Purpose: groups every non-clock/reset signal of serial_demux_ctrl.
// master modport: the controller (consumes line/flags, drives strobes and status).
// slave modport : datapath / environment side (the mirror image).
//   clk_en     cycle qualifier
//   ser_in     serial line (idle high, start bit 0)
//   abort      synchronous frame abort
//   co1/co2    port-bit / count-bit counter terminals
//   coD        data down-counter zero flag
//   init_cnt1/init_cnt2/cnt1/cnt2/sh_en/sh_enD/ld_cntD/cntD  datapath strobes
//   valid      current ser_in bit is payload
//   busy/done/frame_cnt  frame status
interface serial_demux_ctrl_if #(
    parameter int FCW = 8
);
    logic           clk_en;
    logic           ser_in;
    logic           abort;
    logic           co1;
    logic           co2;
    logic           coD;
    logic           init_cnt1;
    logic           init_cnt2;
    logic           cnt1;
    logic           cnt2;
    logic           sh_en;
    logic           sh_enD;
    logic           ld_cntD;
    logic           cntD;
    logic           valid;
    logic           busy;
    logic           done;
    logic [FCW-1:0] frame_cnt;

    modport master (
        input  clk_en, ser_in, abort, co1, co2, coD,
        output init_cnt1, init_cnt2, cnt1, cnt2, sh_en, sh_enD, ld_cntD, cntD,
               valid, busy, done, frame_cnt
    );

    modport slave (
        output clk_en, ser_in, abort, co1, co2, coD,
        input  init_cnt1, init_cnt2, cnt1, cnt2, sh_en, sh_enD, ld_cntD, cntD,
               valid, busy, done, frame_cnt
    );
endinterface

// File: rtl/serial_demux_ctrl.sv
// rtl/serial_demux_ctrl.sv - frame sequencer for the serial-to-parallel port demultiplexer
//
// Purpose: detects a start bit, steps the datapath through 2 port bits, 5 count
// bits, a down-counter load and a payload window of that many bits, and reports
// busy / done / completed-frame count.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  serial_demux_ctrl_if.master (line, counter flags, strobes, status)
module serial_demux_ctrl #(
    parameter int FCW = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_demux_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PORT = 3'd1,
        S_NUM  = 3'd2,
        S_LOAD = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_done;
    logic [FCW-1:0] r_frame_cnt;

    logic w_init_cnt1;
    logic w_init_cnt2;
    logic w_cnt1;
    logic w_cnt2;
    logic w_sh_en;
    logic w_sh_enD;
    logic w_ld_cntD;
    logic w_cntD;
    logic w_valid;
    logic w_enter_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.clk_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_init_cnt1 = 1'b0;
        w_init_cnt2 = 1'b0;
        w_cnt1      = 1'b0;
        w_cnt2      = 1'b0;
        w_sh_en     = 1'b0;
        w_sh_enD    = 1'b0;
        w_ld_cntD   = 1'b0;
        w_cntD      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_init_cnt1 = 1'b1;
                w_init_cnt2 = 1'b1;
                // start bit is consumed here, never shifted
                if (!bus.ser_in) w_next = S_PORT;
            end
            S_PORT: begin
                w_sh_en = 1'b1;
                w_cnt1  = 1'b1;
                if (bus.co1) w_next = S_NUM;
            end
            S_NUM: begin
                w_sh_enD = 1'b1;
                w_cnt2   = 1'b1;
                if (bus.co2) w_next = S_LOAD;
            end
            S_LOAD: begin
                // ser_in here is a guard bit and is ignored
                w_ld_cntD = 1'b1;
                w_next    = S_DATA;
            end
            S_DATA: begin
                w_cntD  = 1'b1;
                // the cycle that sees the zero flag carries no payload, so a
                // count of N yields exactly N valid cycles
                w_valid = ~bus.coD;
                if (bus.coD) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (bus.abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    // only a clean DATA->DONE step counts as a completed frame
    assign w_enter_done = (r_state == S_DATA) && (w_next == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else if (bus.clk_en) begin
            r_done <= w_enter_done;
            if (w_enter_done) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign bus.init_cnt1 = w_init_cnt1;
    assign bus.init_cnt2 = w_init_cnt2;
    assign bus.cnt1      = w_cnt1;
    assign bus.cnt2      = w_cnt2;
    assign bus.sh_en     = w_sh_en;
    assign bus.sh_enD    = w_sh_enD;
    assign bus.ld_cntD   = w_ld_cntD;
    assign bus.cntD      = w_cntD;
    assign bus.valid     = w_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: doc/serial_demux_ctrl.md
Name: serial_demux_ctrl

Overview:
- Moore/Mealy controller that sequences the serial-to-parallel port demultiplexer datapath.
- Per frame it:
  - detects a start bit on ser_in;
  - shifts 2 port-number bits and 5 data-count bits into the datapath shift registers;
  - loads the down-counter with the data count;
  - asserts the demux-valid window for exactly that many data bits.
- Sits between the serial input pin and the datapath; all datapath control strobes originate here.
- Also provides frame status: busy, done, completed-frame count, abort.

Parameters:
- FCW, 8, width of completed-frame counter frame_cnt (wraps modulo 2^FCW).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  cycle qualifier; FSM and frame_cnt advance only when high
- ser_in  in  1  serial line; idle high, start bit = 0
- abort  in  1  synchronous frame abort (qualified by clk_en)
- co1  in  1  port-bit counter terminal (counter == 2'b11)
- co2  in  1  count-bit counter terminal (counter == 3'b111)
- coD  in  1  data down-counter zero flag
- init_cnt1  out  1  load port-bit counter with 2'b10
- init_cnt2  out  1  load count-bit counter with 3'b011
- cnt1  out  1  increment port-bit counter
- cnt2  out  1  increment count-bit counter
- sh_en  out  1  shift port-number register
- sh_enD  out  1  shift data-count register
- ld_cntD  out  1  load down-counter from data-count register
- cntD  out  1  decrement down-counter
- valid  out  1  current ser_in bit is payload, routed to port
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on frame completion (registered)
- frame_cnt  out  FCW  number of frames completed (not aborted)

Behaviour:
- States: IDLE, PORT, NUM, LOAD, DATA, DONE. State register is 3-bit, binary encoded.
- Reset (async): state = IDLE, done = 0, frame_cnt = 0. All combinational outputs then take their IDLE values:
  - init_cnt1 = init_cnt2 = 1;
  - all other outputs = 0.
- State transitions occur on posedge clk only when clk_en = 1. Otherwise state, done and frame_cnt hold.
- Strobe outputs are decoded from state as levels. The datapath applies its own clk_en gating.
- IDLE:
  - init_cnt1 = init_cnt2 = 1.
  - If ser_in == 0, go to PORT. The start bit is consumed, not shifted.
- PORT:
  - sh_en = cnt1 = 1.
  - If co1 == 1, go to NUM. The bit in that cycle is still shifted, giving exactly 2 port bits, MSB first.
- NUM:
  - sh_enD = cnt2 = 1.
  - If co2 == 1, go to LOAD. Exactly 5 count bits, MSB first.
- LOAD:
  - ld_cntD = 1 for one cycle.
  - ser_in is ignored (guard bit).
  - Always go to DATA.
- DATA:
  - cntD = 1.
  - valid = ~coD.
  - If coD == 1, go to DONE.
  - Result: N payload cycles for count N, with N = 0 giving zero valid cycles.
- DONE:
  - Always return to IDLE.
  - On the transition into DONE: done <= 1 and frame_cnt <= frame_cnt + 1 (wraps from 2^FCW-1 to 0).
  - done is cleared on the next enabled edge.
- abort = 1 in any non-IDLE state with clk_en = 1:
  - next state = IDLE;
  - frame_cnt unchanged, no done pulse.
  - abort has priority over all other transitions. It is ignored in IDLE.
- ser_in = 0 arriving in DONE is not treated as a start. A start is recognised only in IDLE, so at least one IDLE cycle separates frames.
- clk_en low mid-frame: FSM freezes. Strobes stay at the current-state levels and have no effect downstream.
- Async rst mid-frame: immediate return to IDLE; frame_cnt cleared.
- Illegal state encodings recover to IDLE on the next enabled edge.

Test Plan:
- Reset, then ser_in = 1 for 10 cycles -> busy = 0, init_cnt1 = init_cnt2 = 1, frame_cnt = 0, no done.
- Start, port bits 10, count 00011 (3), then 3 payload bits (datapath model attached) -> 2 sh_en cycles, 5 sh_enD cycles, 1 ld_cntD cycle, valid high exactly 3 cycles, done pulse, frame_cnt = 1.
- Frame with count 00000 -> LOAD then DATA with valid never high, DONE next cycle, frame_cnt increments.
- clk_en toggled 1/0 alternately through a count-31 frame -> valid high on exactly 31 enabled cycles, state held on disabled cycles.
- abort asserted in NUM after 2 count bits -> IDLE next edge, busy = 0, frame_cnt unchanged, no done. The following frame completes normally.
- FCW = 2, four back-to-back frames -> frame_cnt sequence 1, 2, 3, 0. Async rst during DATA -> busy = 0 and frame_cnt = 0 immediately.
